mem_access_ctrl: RTL and testbench

Memory-stage controller that drives the producer side of the MEM/WB pipeline register. Accepts one instruction per cycle from EX/MEM, performs loads and stores over a req/ack data-memory handshake, stalls upstream while a memory access is outstanding, and presents a registered, one-cycle-valid result bundle (destination register, write enable, result data) for capture into MEM/WB.

---
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store controller feeding MEM/WB; MEM_TIMEOUT_EN adds an access timeout
module mem_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int TO_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_RegWrite,
    input  logic [REG_W-1:0]  ex_RegisterRd,
    input  logic [DATA_W-1:0] ex_AluResult,
    input  logic [DATA_W-1:0] ex_WriteData,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic              out_RegWrite,
    output logic [REG_W-1:0]  out_RegisterRd,
    output logic              out_MemRead,
    output logic [DATA_W-1:0] out_Result,
    output logic              out_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [REG_W-1:0]   lat_rd;
    logic               lat_reg_write;
    logic               lat_mem_read;
    logic               ex_mem_op;

    assign ex_mem_op = ex_MemRead | ex_MemWrite;
    assign stall     = (state == BUSY);

`ifdef MEM_TIMEOUT_EN
    // Abort on the BUSY cycle whose increment would make the counter all-ones.
    localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);
    logic [TO_W-1:0] to_cnt;
`else
    wire [TO_W-1:0] unused_to_w = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            out_valid      <= 1'b0;
            out_RegWrite   <= 1'b0;
            out_RegisterRd <= '0;
            out_MemRead    <= 1'b0;
            out_Result     <= '0;
            out_err        <= 1'b0;
            lat_rd         <= '0;
            lat_reg_write  <= 1'b0;
            lat_mem_read   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            out_err <= 1'b0;
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (ex_valid) begin
                        if (ex_mem_op) begin
                            state         <= BUSY;
                            mem_req       <= 1'b1;
                            mem_we        <= ~ex_MemRead;
                            mem_addr      <= ex_AluResult;
                            mem_wdata     <= ex_WriteData;
                            lat_rd        <= ex_RegisterRd;
                            lat_reg_write <= ex_RegWrite;
                            lat_mem_read  <= ex_MemRead;
`ifdef MEM_TIMEOUT_EN
                            to_cnt        <= '0;
`endif
                        end else begin
                            out_valid      <= 1'b1;
                            out_RegWrite   <= ex_RegWrite && (ex_RegisterRd != '0);
                            out_RegisterRd <= ex_RegisterRd;
                            out_MemRead    <= 1'b0;
                            out_Result     <= ex_AluResult;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state          <= IDLE;
                        mem_req        <= 1'b0;
                        out_valid      <= 1'b1;
                        // Stores never write back, whatever RegWrite said.
                        out_RegWrite   <= lat_reg_write && lat_mem_read && (lat_rd != '0);
                        out_RegisterRd <= lat_rd;
                        out_MemRead    <= lat_mem_read;
                        out_Result     <= lat_mem_read ? mem_rdata : mem_addr;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state          <= IDLE;
                        mem_req        <= 1'b0;
                        out_valid      <= 1'b1;
                        out_RegWrite   <= 1'b0;
                        out_RegisterRd <= lat_rd;
                        out_MemRead    <= lat_mem_read;
                        out_err        <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int TO_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid, ex_MemRead, ex_MemWrite, ex_RegWrite;
    logic [REG_W-1:0]  ex_RegisterRd;
    logic [DATA_W-1:0] ex_AluResult, ex_WriteData;
    logic              stall, mem_req, mem_we, mem_ack;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic              out_valid, out_RegWrite, out_MemRead, out_err;
    logic [REG_W-1:0]  out_RegisterRd;
    logic [DATA_W-1:0] out_Result;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] last_result = '0;
    logic [REG_W-1:0]  last_rd = '0;

    mem_access_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite), .ex_RegisterRd(ex_RegisterRd),
        .ex_AluResult(ex_AluResult), .ex_WriteData(ex_WriteData),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_RegWrite(out_RegWrite),
        .out_RegisterRd(out_RegisterRd), .out_MemRead(out_MemRead),
        .out_Result(out_Result), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic junk_ex();
        ex_valid      = 1'($urandom);
        ex_MemRead    = 1'($urandom);
        ex_MemWrite   = 1'($urandom);
        ex_RegWrite   = 1'($urandom);
        ex_RegisterRd = REG_W'($urandom);
        ex_AluResult  = $urandom;
        ex_WriteData  = $urandom;
    endtask

    task automatic do_idle();
        ex_valid = 1'b0;
        mem_ack  = 1'($urandom);
        mem_rdata = $urandom;
        tick();
        check("idle_valid", out_valid, 0);
        check("idle_hold_result", out_Result, last_result);
        check("idle_hold_rd", out_RegisterRd, last_rd);
        check("idle_err", out_err, 0);
    endtask

    task automatic do_alu(input logic rw, input logic [REG_W-1:0] rd, input logic [31:0] alu);
        ex_valid = 1'b1; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
        ex_RegWrite = rw; ex_RegisterRd = rd; ex_AluResult = alu; ex_WriteData = $urandom;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        check("alu_stall_pre", stall, 0);
        tick();
        check("alu_valid", out_valid, 1);
        check("alu_regwrite", out_RegWrite, rw && (rd != 0));
        check("alu_rd", out_RegisterRd, rd);
        check("alu_memread", out_MemRead, 0);
        check("alu_result", out_Result, alu);
        check("alu_stall", stall, 0);
        check("alu_req", mem_req, 0);
        check("alu_err", out_err, 0);
        last_result = alu;
        last_rd = rd;
    endtask

    task automatic do_mem(input logic is_load, input logic rw, input logic [REG_W-1:0] rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rdata);
        logic [31:0] exp_res;
        ex_valid = 1'b1; ex_MemRead = is_load;
        ex_MemWrite = is_load ? 1'($urandom) : 1'b1;
        ex_RegWrite = rw; ex_RegisterRd = rd; ex_AluResult = addr; ex_WriteData = wdata;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        tick();
        for (int k = 0; k <= waits; k++) begin
            check("mem_req", mem_req, 1);
            check("mem_stall", stall, 1);
            check("mem_we", mem_we, !is_load);
            check("mem_addr", mem_addr, addr);
            check("mem_wdata", mem_wdata, wdata);
            check("mem_busy_valid", out_valid, 0);
            junk_ex();
            mem_ack = (k == waits);
            mem_rdata = (k == waits) ? rdata : $urandom;
            tick();
        end
        mem_ack = 1'b0;
        ex_valid = 1'b0;
        exp_res = is_load ? rdata : addr;
        check("mem_valid", out_valid, 1);
        check("mem_regwrite", out_RegWrite, rw && is_load && (rd != 0));
        check("mem_rd", out_RegisterRd, rd);
        check("mem_memread", out_MemRead, is_load);
        check("mem_result", out_Result, exp_res);
        check("mem_done_stall", stall, 0);
        check("mem_done_req", mem_req, 0);
        check("mem_err", out_err, 0);
        last_result = exp_res;
        last_rd = rd;
    endtask

    initial begin
        int busy;
        rst = 1'b1;
        ex_valid = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0; ex_RegWrite = 1'b0;
        ex_RegisterRd = '0; ex_AluResult = '0; ex_WriteData = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);

        check("rst_stall", stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_valid", out_valid, 0);
        check("rst_regwrite", out_RegWrite, 0);
        check("rst_rd", out_RegisterRd, 0);
        check("rst_memread", out_MemRead, 0);
        check("rst_result", out_Result, 0);
        check("rst_err", out_err, 0);
        rst = 1'b0;

        do_alu(1'b1, 5'd3, 32'h1234);
        do_idle();
        do_mem(1'b1, 1'b1, 5'd8, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        do_mem(1'b0, 1'b1, 5'd9, 32'h40, 32'hA5A5, 3, 32'h0);
        do_alu(1'b1, 5'd4, 32'h5555);
        do_mem(1'b1, 1'b1, 5'd0, 32'h200, 32'h0, 1, 32'hCAFEF00D);
        do_alu(1'b1, 5'd0, 32'h77);
        do_alu(1'b0, 5'd6, 32'h88);

        // Reset in the second BUSY cycle, with a coincident ack.
        do_mem(1'b1, 1'b1, 5'd2, 32'h300, 32'h0, 0, 32'h11);
        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0; ex_RegWrite = 1'b1;
        ex_RegisterRd = 5'd5; ex_AluResult = 32'h400;
        mem_ack = 1'b0;
        tick();
        ex_valid = 1'b0;
        check("rstb_req1", mem_req, 1);
        tick();
        check("rstb_req2", mem_req, 1);
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h99;
        tick();
        rst = 1'b0;
        check("rstb_req", mem_req, 0);
        check("rstb_stall", stall, 0);
        check("rstb_valid", out_valid, 0);
        last_result = '0;
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            tick();
            check("rstb_late_ack_valid", out_valid, 0);
            check("rstb_late_ack_req", mem_req, 0);
        end
        mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0; ex_RegWrite = 1'b1;
        ex_RegisterRd = 5'd7; ex_AluResult = 32'h500;
        tick();
        ex_valid = 1'b0;
        busy = 0;
        while (mem_req && busy < 40) begin
            busy++;
            mem_ack = 1'b0;
            tick();
        end
        check("to_busy_cycles", busy, 15);
        check("to_err", out_err, 1);
        check("to_valid", out_valid, 1);
        check("to_regwrite", out_RegWrite, 0);
        check("to_rd", out_RegisterRd, 7);
        check("to_stall", stall, 0);
        last_rd = 5'd7;
        do_idle();
        do_mem(1'b1, 1'b1, 5'd10, 32'h600, 32'h0, 14, 32'h12345678);
`else
        busy = 0;
        do_mem(1'b1, 1'b1, 5'd10, 32'h600, 32'h0, 100, 32'h12345678);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: do_idle();
                1: do_alu(1'($urandom), REG_W'($urandom), $urandom);
                2: do_mem(1'b1, 1'($urandom), REG_W'($urandom), $urandom, $urandom,
                          $urandom_range(0, 6), $urandom);
                default: do_mem(1'b0, 1'($urandom), REG_W'($urandom), $urandom, $urandom,
                                $urandom_range(0, 6), $urandom);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
